// File: rtl/alu4_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu4_req_arbiter
// Description : Shares one combinational alu4 datapath between two requesters.
//               Each requester issues an op/A/B command over a valid/ready
//               handshake. Grants use round-robin priority. The ALU operands
//               are driven from registers, and the ALU result and flags are
//               returned on a single response channel tagged with the
//               requester id.
// Ports       : clk, rst                     clock, sync active-high reset
//               r0_*_i / r0_ready_o          requester 0 command channel
//               r1_*_i / r1_ready_o          requester 1 command channel
//               alu_a_o/alu_b_o/alu_op_o     registered operands to alu4
//               alu_result/carry/zero_i      combinational outputs of alu4
//               rsp_*_o / rsp_ready_i        response channel
//               grant_cnt0_o/grant_cnt1_o    per-port grant counters
// Options     : ALU4_ARB_STATS_EN - builds the saturating grant counters.
//               When it is undefined, both counters read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_req_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid_i,
    input  logic [OP_W-1:0]   r0_op_i,
    input  logic [DATA_W-1:0] r0_a_i,
    input  logic [DATA_W-1:0] r0_b_i,
    output logic              r0_ready_o,
    input  logic              r1_valid_i,
    input  logic [OP_W-1:0]   r1_op_i,
    input  logic [DATA_W-1:0] r1_a_i,
    input  logic [DATA_W-1:0] r1_b_i,
    output logic              r1_ready_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_carry_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_carry_o,
    output logic              rsp_zero_o,
    output logic [CNT_W-1:0]  grant_cnt0_o,
    output logic [CNT_W-1:0]  grant_cnt1_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                id_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [OP_W-1:0]     alu_op_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_carry_q, rsp_zero_q;
    logic                grant0, grant1;

    // Next-state and grant decode. Port 0 wins when it is the only requester,
    // or on a tie when port 1 was granted last.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r0_valid_i && (!r1_valid_i || last_grant_q)) begin
                    grant0 = 1'b1;
                end else if (r1_valid_i) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is masked during reset so no requester believes it was accepted
    // by a cycle that the reset throws away.
    assign r0_ready_o = grant0 & ~rst;
    assign r1_ready_o = grant1 & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant0) begin
                alu_a_q      <= r0_a_i;
                alu_b_q      <= r0_b_i;
                alu_op_q     <= r0_op_i;
                id_q         <= 1'b0;
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                alu_a_q      <= r1_a_i;
                alu_b_q      <= r1_b_i;
                alu_op_q     <= r1_op_i;
                id_q         <= 1'b1;
                last_grant_q <= 1'b1;
            end
            // The operands have been stable for a full cycle in EXEC, so the
            // ALU outputs are settled and can be captured.
            if (state_q == ST_EXEC) begin
                rsp_result_q <= alu_result_i;
                rsp_carry_q  <= alu_carry_i;
                rsp_zero_q   <= alu_zero_i;
                rsp_valid_q  <= 1'b1;
            end else if (state_q == ST_RESP && rsp_ready_i) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_carry_o  = rsp_carry_q;
    assign rsp_zero_o   = rsp_zero_q;

`ifdef ALU4_ARB_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q;

    // Saturating counters: once at all-ones they stay there until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            if (grant0 && grant_cnt0_q != C_CNT_MAX) begin
                grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
            end
            if (grant1 && grant_cnt1_q != C_CNT_MAX) begin
                grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0_o = grant_cnt0_q;
    assign grant_cnt1_o = grant_cnt1_q;
`else
    assign grant_cnt0_o = '0;
    assign grant_cnt1_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu4_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_req_arbiter
// Description : Directed self-checking bench for alu4_req_arbiter with a
//               behavioural alu4 attached to the alu_* ports.
//               alu4 opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//               101 NOT A, 110 INC A, 111 DEC A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu4_req_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic [2:0] r0_op = '0, r1_op = '0;
    logic [3:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic       r0_ready, r1_ready;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero;
    logic [7:0] grant_cnt0, grant_cnt1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu4_req_arbiter #(.DATA_W(4), .OP_W(3), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .r0_valid_i   (r0_valid),
        .r0_op_i      (r0_op),
        .r0_a_i       (r0_a),
        .r0_b_i       (r0_b),
        .r0_ready_o   (r0_ready),
        .r1_valid_i   (r1_valid),
        .r1_op_i      (r1_op),
        .r1_a_i       (r1_a),
        .r1_b_i       (r1_b),
        .r1_ready_o   (r1_ready),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_carry_i  (alu_carry),
        .alu_zero_i   (alu_zero),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_carry_o  (rsp_carry),
        .rsp_zero_o   (rsp_zero),
        .grant_cnt0_o (grant_cnt0),
        .grant_cnt1_o (grant_cnt1)
    );

    // Behavioural alu4
    logic [4:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_op)
            3'b000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_wide = {1'b0, alu_a & alu_b};
            3'b011: alu_wide = {1'b0, alu_a | alu_b};
            3'b100: alu_wide = {1'b0, alu_a ^ alu_b};
            3'b101: alu_wide = {1'b0, ~alu_a};
            3'b110: alu_wide = {1'b0, alu_a} + 5'd1;
            default: alu_wide = {1'b0, alu_a} - 5'd1;
        endcase
    end
    assign alu_result = alu_wide[3:0];
    assign alu_carry  = alu_wide[4];
    assign alu_zero   = (alu_wide[3:0] == 4'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one command with rsp_ready=1 and checks its response.
    // Returns at the negedge of the RESP cycle; the handshake follows.
    task automatic do_cmd(input bit port, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp_r, input bit exp_z,
                          input string tag);
        bit got;
        @(negedge clk);
        if (!port) begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (port ? r1_ready : r0_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " ready"}, 32'(got), 1);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " rsp_valid"}, 32'(got), 1);
        chk({tag, " id"}, 32'(rsp_id), 32'(port));
        chk({tag, " result"}, 32'(rsp_result), 32'(exp_r));
        chk({tag, " zero"}, 32'(rsp_zero), 32'(exp_z));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gids[4];
        int ng;
        int rids[4];
        int rres[4];
        int nr;
        int seen;
        logic [7:0] exp_c0, exp_c1;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst alu_a", 32'(alu_a), 0);
        chk("rst alu_b", 32'(alu_b), 0);
        chk("rst alu_op", 32'(alu_op), 0);
        chk("rst rsp_result", 32'(rsp_result), 0);
        chk("rst readies", 32'({r0_ready, r1_ready}), 0);
        chk("rst cnts", 32'({grant_cnt0, grant_cnt1}), 0);
        rst = 1'b0;

        // ---- Single ADD with latency ----
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 3'b000; r0_a = 4'b0101; r0_b = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        chk("add r0_ready", 32'(r0_ready), 1);
        chk("add r1_ready", 32'(r1_ready), 0);
        @(negedge clk);
        r0_valid = 1'b0;
        chk("add exec rsp_valid", 32'(rsp_valid), 0);
        chk("add alu_a", 32'(alu_a), 32'h5);
        chk("add alu_b", 32'(alu_b), 32'h3);
        chk("add alu_op", 32'(alu_op), 0);
        @(negedge clk);
        chk("add rsp_valid", 32'(rsp_valid), 1);
        chk("add result", 32'(rsp_result), 32'h8);
        chk("add carry", 32'(rsp_carry), 0);
        chk("add zero", 32'(rsp_zero), 0);
        chk("add id", 32'(rsp_id), 0);
        @(negedge clk);
        chk("add after hs", 32'(rsp_valid), 0);

        // ---- Tie and fairness ----
        reset_pulse();
        r0_valid = 1'b1; r0_op = 3'b010; r0_a = 4'b1100; r0_b = 4'b1010;
        r1_valid = 1'b1; r1_op = 3'b100; r1_a = 4'b1100; r1_b = 4'b1010;
        ng = 0; nr = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (r0_ready && ng < 4) begin gids[ng] = 0; ng++; end
            if (r1_ready && ng < 4) begin gids[ng] = 1; ng++; end
            if (rsp_valid && nr < 4) begin
                rids[nr] = 32'(rsp_id); rres[nr] = 32'(rsp_result); nr++;
            end
            if (c < 11) @(negedge clk);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("fair ngrants", ng, 4);
        chk("fair nrsp", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair grant%0d", i), gids[i], i % 2);
            chk($sformatf("fair rsp_id%0d", i), rids[i], i % 2);
            chk($sformatf("fair result%0d", i), rres[i], (i % 2 == 0) ? 32'h8 : 32'h6);
        end

        // ---- Backpressure ----
        @(negedge clk);
        rsp_ready = 1'b0;
        r1_valid = 1'b1; r1_op = 3'b110; r1_a = 4'b1111; r1_b = 4'b0000;
        #1;
        chk("bp r1_ready", 32'(r1_ready), 1);
        @(negedge clk);
        r1_valid = 1'b0;
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 3'b000; r0_a = 4'b0001; r0_b = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 1);
            chk($sformatf("bp hold%0d result", i), 32'(rsp_result), 0);
            chk($sformatf("bp hold%0d zero", i), 32'(rsp_zero), 1);
            chk($sformatf("bp hold%0d id", i), 32'(rsp_id), 1);
            chk($sformatf("bp hold%0d readies", i), 32'({r0_ready, r1_ready}), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp hs-cycle r0_ready", 32'(r0_ready), 0);
        @(negedge clk);
        chk("bp after hs valid", 32'(rsp_valid), 0);
        chk("bp next grant r0", 32'(r0_ready), 1);
        @(negedge clk);
        r0_valid = 1'b0;
        @(negedge clk);
        chk("bp next rsp valid", 32'(rsp_valid), 1);
        chk("bp next rsp result", 32'(rsp_result), 32'h2);
        chk("bp next rsp id", 32'(rsp_id), 0);

        // ---- Valid dropped before ready ----
        @(negedge clk);
        r1_valid = 1'b1; r1_op = 3'b000; r1_a = 4'b0010; r1_b = 4'b0011;
        #1;
        chk("drop r1_ready", 32'(r1_ready), 1);
        @(negedge clk);
        r1_valid = 1'b0;
        r0_valid = 1'b1; r0_op = 3'b000; r0_a = 4'b0111; r0_b = 4'b0111;
        #1;
        chk("drop exec r0_ready", 32'(r0_ready), 0);
        @(negedge clk);
        r0_valid = 1'b0;
        chk("drop rsp result", 32'(rsp_result), 32'h5);
        chk("drop rsp id", 32'(rsp_id), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || r0_ready) seen++;
        end
        chk("drop no extra", seen, 0);

        // ---- Reset during EXEC ----
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 3'b001; r0_a = 4'b1000; r0_b = 4'b0011;
        #1;
        chk("rmid r0_ready", 32'(r0_ready), 1);
        @(negedge clk);
        r0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rmid rsp_valid", 32'(rsp_valid), 0);
        chk("rmid alu", 32'({alu_a, alu_b, 1'b0, alu_op}), 0);
        chk("rmid rsp", 32'({rsp_id, rsp_result, rsp_carry, rsp_zero}), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rmid no stale", seen, 0);
        do_cmd(1'b0, 3'b001, 4'b1000, 4'b0011, 4'b0101, 1'b0, "rmid retry");

        // ---- Grant statistics ----
        reset_pulse();
        do_cmd(1'b0, 3'b000, 4'b0001, 4'b0010, 4'b0011, 1'b0, "st p0 add");
        do_cmd(1'b0, 3'b011, 4'b0101, 4'b0010, 4'b0111, 1'b0, "st p0 or");
        do_cmd(1'b0, 3'b101, 4'b0000, 4'b0000, 4'b1111, 1'b0, "st p0 not");
        do_cmd(1'b1, 3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, "st p1 dec");
        do_cmd(1'b1, 3'b100, 4'b1111, 4'b1111, 4'b0000, 1'b1, "st p1 xor");
        @(negedge clk);
`ifdef ALU4_ARB_STATS_EN
        exp_c0 = 8'd3;
        exp_c1 = 8'd2;
`else
        exp_c0 = 8'd0;
        exp_c1 = 8'd0;
`endif
        chk("stats cnt0", 32'(grant_cnt0), 32'(exp_c0));
        chk("stats cnt1", 32'(grant_cnt1), 32'(exp_c1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
